clkgate_ctrl_nch: RTL and testbench
===================================

Name: clkgate_ctrl_nch

Overview:
Multi-channel clock-gating controller that generalises the single latch-based ICG cell to NCH gated clocks. Each channel has its own enable FSM with idle-based automatic gating: a programmable hysteresis threshold, a wake request/acknowledge handshake and a test-mode override. It sits at the clock-tree root of a subsystem and drives per-unit gated clocks.

Parameters:
NCH, 4, number of gated clock channels (1..32)
IDLE_W, 8, width of idle counter and threshold
WAKE_CYC, 2, gated-clock cycles a channel runs in WAKE before acknowledging (1..2^IDLE_W-1)

Ports:
CK  input  1  free-running source clock
RN  input  1  asynchronous active-low reset
TE  input  1  test enable; forces every GCK to follow CK, bypassing the FSMs
ACTIVE  input  NCH  per-channel activity indication, sampled on CK rise
WAKE_REQ  input  NCH  per-channel level wake request; held until WAKE_ACK
IDLE_THR  input  IDLE_W  idle cycles before gating; 0 disables auto-gating
WAKE_ACK  output  NCH  high while channel is in RUN and WAKE_REQ is high
GATED  output  NCH  high while channel is in OFF
GCK  output  NCH  gated clocks

Behaviour:
- Reset: one clock and one reset only. Reset is asynchronous and active-low on RN.
- Reset values:
  - all FSMs in RUN, counters 0, en_q = all ones
  - GATED = 0, WAKE_ACK = 0
  - GCK follows CK once the latch is transparent (CK low)
- Gating cell, per channel: level latch transparent while CK = 0 captures (en_q[i] | TE); GCK[i] = CK & latch. The cell is glitch-free. An en_q change during CK high takes effect at the next CK high phase.
- RN asserted while CK high: the latch holds its value until CK falls. No truncated pulses.
- Per-channel FSM, updated on CK rise:
  - RUN: en_q = 1.
    - If ACTIVE = 1, WAKE_REQ = 1 or IDLE_THR = 0: counter clears to 0.
    - Otherwise counter increments, saturating at all-ones.
    - If ACTIVE = 0, WAKE_REQ = 0, IDLE_THR != 0 and counter + 1 >= IDLE_THR: go to OFF, en_q = 0.
    - Result: with THR = N, the Nth consecutive idle sample gates. GCK drops from the CK high phase after that edge.
  - OFF: en_q = 0, GATED = 1. ACTIVE = 1 or WAKE_REQ = 1 sampled -> WAKE, en_q = 1 at that edge, counter cleared.
  - WAKE: en_q = 1. Counter increments each edge. After WAKE_CYC edges in WAKE -> RUN, counter cleared. ACTIVE and WAKE_REQ are ignored in WAKE.
- WAKE_ACK[i] = (state == RUN) & WAKE_REQ[i], registered. It rises on the edge entering RUN if WAKE_REQ is high.
  - A request arriving while already in RUN: ACK rises the next edge.
  - ACK deasserts the edge after WAKE_REQ falls.
- Simultaneous events:
  - Activity and threshold hit in the same cycle: activity wins, stay RUN.
  - IDLE_THR lowered mid-count below the current count: gate on the next idle sample.
  - IDLE_THR raised: keep counting.
  - IDLE_THR written to 0 while in OFF: the channel stays OFF until woken; 0 only prevents entry into OFF.
- TE = 1: GCK = CK on all channels. FSMs keep running and GATED still reports FSM state. Deasserting TE restores FSM control on the next CK low phase.
- Channels are fully independent. No cross-channel ordering.

Decomposition:
- Shared package clkgate_pkg:
  - state enum {RUN, OFF, WAKE} (2 bits)
  - localparam encodings
  - function sat_inc(IDLE_W)
- Sub-module clkgate_icg (CK, TE, EN, GCK): the single latch + AND cell, instantiated NCH times. Only this cell holds a latch.
- FSM and counter logic are a generate loop in the top.

Test Plan (NCH = 4, IDLE_W = 8, WAKE_CYC = 2, TE = 0 unless stated):
1. Reset, then ACTIVE = 4'hF, IDLE_THR = 4 -> GCK[3:0] toggle with CK; GATED = 0, WAKE_ACK = 0.
2. ACTIVE[0] drops to 0 at edge k -> GATED[0] rises at edge k+3 (4th idle sample); GCK[0] has no pulses after edge k+3; channels 1-3 unaffected.
3. Channel 0 OFF, WAKE_REQ[0] = 1 at edge m -> WAKE at m, GCK[0] resumes, RUN at m+2, WAKE_ACK[0] = 1 at m+2; WAKE_REQ[0] low at m+5 -> WAKE_ACK[0] = 0 at m+6.
4. IDLE_THR = 0 with ACTIVE = 0 for 300 cycles -> GATED stays 0. Then IDLE_THR = 1 -> GATED = 4'hF after one edge.
5. All channels OFF, TE = 1 -> all GCK follow CK within the next CK low phase, GATED stays 4'hF. TE = 0 -> gating resumes.
6. RN pulsed low mid-CK-high while channels are OFF/WAKE -> no GCK pulse shorter than CK high. After RN release, all RUN, counters 0, GATED = 0.

Source files
------------

// File: rtl/clkgate_pkg.sv
// Shared types and helpers for the multi-channel clock-gating controller.
package clkgate_pkg;

  localparam logic [1:0] ENC_RUN  = 2'b00;
  localparam logic [1:0] ENC_OFF  = 2'b01;
  localparam logic [1:0] ENC_WAKE = 2'b10;

  typedef enum logic [1:0] {
    ST_RUN  = ENC_RUN,
    ST_OFF  = ENC_OFF,
    ST_WAKE = ENC_WAKE
  } cg_state_e;

  // Saturating increment of the low w bits of v (w in 1..32).
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input int w);
    logic [31:0] max_v;
    if (w >= 32) begin
      max_v = 32'hFFFF_FFFF;
    end else begin
      max_v = (32'd1 << w) - 32'd1;
    end
    if (v >= max_v) begin
      sat_inc = max_v;
    end else begin
      sat_inc = v + 32'd1;
    end
  endfunction

endpackage

// File: rtl/clkgate_icg.sv
// Glitch-free integrated clock-gating cell: low-transparent latch followed by an AND.
module clkgate_icg (
  input  logic CK,
  input  logic TE,
  input  logic EN,
  output logic GCK
);

  logic latch_q;

  // Enable is captured only while the source clock is low.
  always_latch begin
    if (!CK) begin
      latch_q = EN | TE;
    end
  end

  assign GCK = CK & latch_q;

endmodule

// File: rtl/clkgate_ctrl_nch.sv
// NCH-channel clock-gating controller: per-channel idle/wake FSM driving one ICG cell each.
module clkgate_ctrl_nch
  import clkgate_pkg::*;
#(
  parameter int NCH      = 4,
  parameter int IDLE_W   = 8,
  parameter int WAKE_CYC = 2
) (
  input  logic              CK,
  input  logic              RN,
  input  logic              TE,
  input  logic [NCH-1:0]    ACTIVE,
  input  logic [NCH-1:0]    WAKE_REQ,
  input  logic [IDLE_W-1:0] IDLE_THR,
  output logic [NCH-1:0]    WAKE_ACK,
  output logic [NCH-1:0]    GATED,
  output logic [NCH-1:0]    GCK
);

  localparam logic [IDLE_W:0] WAKE_LIM = (IDLE_W+1)'(WAKE_CYC);
  localparam logic [IDLE_W:0] ONE_EXT  = (IDLE_W+1)'(1);

  logic            thr_zero_s;
  logic [IDLE_W:0] thr_ext_s;

  assign thr_zero_s = (IDLE_THR == {IDLE_W{1'b0}});
  assign thr_ext_s  = {1'b0, IDLE_THR};

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    cg_state_e         state_q, state_d;
    logic [IDLE_W-1:0] cnt_q, cnt_d;
    logic [IDLE_W:0]   cnt_nxt_s;
    logic              en_q, en_d;
    logic              gated_q, gated_d;
    logic              ack_q, ack_d;

    // Next-state, counter and registered-output decode for one channel.
    always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      cnt_nxt_s = {1'b0, cnt_q} + ONE_EXT;
      case (state_q)
        ST_RUN: begin
          if (ACTIVE[i] | WAKE_REQ[i] | thr_zero_s) begin
            cnt_d = {IDLE_W{1'b0}};
          end else begin
            cnt_d = IDLE_W'(sat_inc(32'(cnt_q), IDLE_W));
            // Compare in IDLE_W+1 bits so a saturated counter still reaches any threshold.
            if (cnt_nxt_s >= thr_ext_s) begin
              state_d = ST_OFF;
            end else begin
              state_d = ST_RUN;
            end
          end
        end
        ST_OFF: begin
          if (ACTIVE[i] | WAKE_REQ[i]) begin
            state_d = ST_WAKE;
            cnt_d   = {IDLE_W{1'b0}};
          end else begin
            state_d = ST_OFF;
          end
        end
        ST_WAKE: begin
          if (cnt_nxt_s >= WAKE_LIM) begin
            state_d = ST_RUN;
            cnt_d   = {IDLE_W{1'b0}};
          end else begin
            state_d = ST_WAKE;
            cnt_d   = IDLE_W'(sat_inc(32'(cnt_q), IDLE_W));
          end
        end
        default: begin
          state_d = ST_RUN;
          cnt_d   = {IDLE_W{1'b0}};
        end
      endcase
      en_d    = (state_d != ST_OFF);
      gated_d = (state_d == ST_OFF);
      ack_d   = (state_d == ST_RUN) & WAKE_REQ[i];
    end

    // Channel state register.
    always_ff @(posedge CK or negedge RN) begin
      if (!RN) begin
        state_q <= ST_RUN;
        cnt_q   <= {IDLE_W{1'b0}};
        en_q    <= 1'b1;
        gated_q <= 1'b0;
        ack_q   <= 1'b0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        en_q    <= en_d;
        gated_q <= gated_d;
        ack_q   <= ack_d;
      end
    end

    assign GATED[i]    = gated_q;
    assign WAKE_ACK[i] = ack_q;

    clkgate_icg u_icg (
      .CK  (CK),
      .TE  (TE),
      .EN  (en_q),
      .GCK (GCK[i])
    );
  end

endmodule

// File: tb/tb_clkgate_ctrl_nch.sv
// Directed self-checking bench for clkgate_ctrl_nch (NCH=4, IDLE_W=8, WAKE_CYC=2).
module tb_clkgate_ctrl_nch;

  logic       CK;
  logic       RN;
  logic       TE;
  logic [3:0] ACTIVE;
  logic [3:0] WAKE_REQ;
  logic [7:0] IDLE_THR;
  logic [3:0] WAKE_ACK;
  logic [3:0] GATED;
  logic [3:0] GCK;

  int n_vec = 0;
  int n_err = 0;

  clkgate_ctrl_nch #(.NCH(4), .IDLE_W(8), .WAKE_CYC(2)) dut (
    .CK       (CK),
    .RN       (RN),
    .TE       (TE),
    .ACTIVE   (ACTIVE),
    .WAKE_REQ (WAKE_REQ),
    .IDLE_THR (IDLE_THR),
    .WAKE_ACK (WAKE_ACK),
    .GATED    (GATED),
    .GCK      (GCK)
  );

  initial begin
    CK = 1'b0;
    forever #5 CK = ~CK;
  end

  // Every gated-clock pulse must last a full CK high phase (5 time units).
  for (genvar g = 0; g < 4; g++) begin : g_mon
    time t_rise = 0;
    bit  seen   = 1'b0;
    always @(posedge GCK[g]) begin
      t_rise = $time;
      seen   = 1'b1;
    end
    always @(negedge GCK[g]) begin
      if (seen) begin
        n_vec++;
        assert (($time - t_rise) >= 64'd5) else begin
          n_err++;
          $error("FAIL pulse_width ch%0d: got %0t required >= 5", g, $time - t_rise);
        end
      end
    end
  end

  task automatic step();
    @(posedge CK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    RN = 1'b1; TE = 1'b0; ACTIVE = 4'h0; WAKE_REQ = 4'h0; IDLE_THR = 8'd4;
    #1 RN = 1'b0;
    #1;
    chk("rst_gated", 32'(GATED), 32'h0);
    chk("rst_ack", 32'(WAKE_ACK), 32'h0);
    chk("rst_gck_low", 32'(GCK), 32'h0);
    ACTIVE = 4'hF;
    #10 RN = 1'b1;

    // 1: all active, clocks run
    step();
    chk("t1_gck_high", 32'(GCK), 32'hF);
    chk("t1_gated", 32'(GATED), 32'h0);
    chk("t1_ack", 32'(WAKE_ACK), 32'h0);
    #5;
    chk("t1_gck_low", 32'(GCK), 32'h0);
    step();

    // 2: channel 0 idles, gates on 4th idle sample
    ACTIVE = 4'hE;
    step();
    chk("t2_k0_gated", 32'(GATED), 32'h0);
    step();
    step();
    chk("t2_k2_gated", 32'(GATED), 32'h0);
    step();
    chk("t2_k3_gated", 32'(GATED), 32'h1);
    chk("t2_k3_gck", 32'(GCK), 32'hF);
    step();
    chk("t2_k4_gck", 32'(GCK), 32'hE);
    chk("t2_k4_gated", 32'(GATED), 32'h1);

    // 3: wake handshake on channel 0
    WAKE_REQ = 4'h1;
    step();
    chk("t3_m_gated", 32'(GATED), 32'h0);
    chk("t3_m_gck", 32'(GCK), 32'hE);
    step();
    chk("t3_m1_gck", 32'(GCK), 32'hF);
    chk("t3_m1_ack", 32'(WAKE_ACK), 32'h0);
    step();
    chk("t3_m2_ack", 32'(WAKE_ACK), 32'h1);
    step();
    step();
    step();
    chk("t3_m5_ack", 32'(WAKE_ACK), 32'h1);
    WAKE_REQ = 4'h0;
    step();
    chk("t3_m6_ack", 32'(WAKE_ACK), 32'h0);

    // 4: threshold 0 disables gating, then threshold 1 gates after one edge
    IDLE_THR = 8'd0;
    ACTIVE = 4'h0;
    for (int n = 0; n < 300; n++) begin
      step();
      chk("t4_thr0_gated", 32'(GATED), 32'h0);
    end
    IDLE_THR = 8'd1;
    step();
    chk("t4_thr1_gated", 32'(GATED), 32'hF);

    // 5: test-mode override while all channels are gated
    step();
    chk("t5_off_gck", 32'(GCK), 32'h0);
    TE = 1'b1;
    #1;
    chk("t5_te_mid_high", 32'(GCK), 32'h0);
    step();
    chk("t5_te_gck", 32'(GCK), 32'hF);
    chk("t5_te_gated", 32'(GATED), 32'hF);
    TE = 1'b0;
    step();
    chk("t5_untest_gck", 32'(GCK), 32'h0);
    chk("t5_untest_gated", 32'(GATED), 32'hF);

    // 6: reset mid-high with channels in WAKE/OFF
    WAKE_REQ = 4'h3;
    step();
    chk("t6_wake_gated", 32'(GATED), 32'hC);
    chk("t6_wake_gck0", 32'(GCK), 32'h0);
    WAKE_REQ = 4'h0;
    IDLE_THR = 8'd4;
    step();
    chk("t6_wake_gck1", 32'(GCK), 32'h3);
    #1 RN = 1'b0;
    #1;
    chk("t6_rst_gated", 32'(GATED), 32'h0);
    chk("t6_rst_ack", 32'(WAKE_ACK), 32'h0);
    chk("t6_rst_gck_hold", 32'(GCK), 32'h3);
    #1;
    chk("t6_rst_gck_hold2", 32'(GCK), 32'h3);
    #3;
    chk("t6_rst_gck_low", 32'(GCK), 32'h0);
    RN = 1'b1;
    step();
    chk("t6_rel_gck", 32'(GCK), 32'hF);
    chk("t6_rel_gated", 32'(GATED), 32'h0);
    step();
    chk("t6_rel_cnt2_gated", 32'(GATED), 32'h0);

    // 7: threshold lowered below count; activity wins over a threshold hit
    IDLE_THR = 8'd2;
    ACTIVE = 4'h2;
    step();
    chk("t7_lower_gated", 32'(GATED), 32'hD);
    ACTIVE = 4'h0;
    step();
    chk("t7_ch1_cnt1", 32'(GATED), 32'hD);
    step();
    chk("t7_ch1_off", 32'(GATED), 32'hF);
    IDLE_THR = 8'd0;
    step();
    chk("t7_thr0_stay_off", 32'(GATED), 32'hF);
    ACTIVE = 4'h4;
    step();
    chk("t7_ch2_wake", 32'(GATED), 32'hB);
    ACTIVE = 4'h0;
    step();
    step();
    chk("t7_ch2_run", 32'(GATED), 32'hB);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
